spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter ADDR_W, default 7, register address width.
REQ-002 Parameter STATUS_BYTE, default 8'hA5, byte returned on tx_data while the command byte shifts.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ss  input  1  slave select, high = deselected, pre-synchronized to clk.
REQ-006 rx_valid  input  1  one-clk pulse, a received SPI byte is on rx_data, pre-synchronized.
REQ-007 rx_data  input  8  received byte, valid with rx_valid.
REQ-008 tx_data  output  8  next byte to load into the SPI shifter.
REQ-009 bus_addr  output  ADDR_W  register address.
REQ-010 bus_wdata  output  8  write data.
REQ-011 bus_we  output  1  one-clk write strobe.
REQ-012 bus_re  output  1  one-clk read strobe.
REQ-013 bus_rdata  input  8  read data, valid exactly 1 clk after bus_re.
REQ-014 busy  output  1  high while a frame is open (state not IDLE).
REQ-015 overrun  output  1  sticky: rx_valid arrived while a read fetch was pending.

Function
REQ-016 States: IDLE, CMD, WR, RD_FETCH, RD_WAIT; encoding from package.
REQ-017 IDLE -> CMD one clk after ss is sampled low; tx_data = STATUS_BYTE in CMD.
REQ-018 In CMD, rx_valid decodes rx_data: bit7=1 read, bit7=0 write; bits[ADDR_W-1:0] load the address counter.
REQ-019 Write command: CMD -> WR; each later rx_valid drives bus_we=1 for exactly one clk, the cycle after rx_valid, with bus_wdata = rx_data and bus_addr = current address; the address then increments.
REQ-020 Read command: CMD -> RD_FETCH; bus_re=1 for one clk, the cycle after rx_valid; RD_WAIT captures bus_rdata into tx_data the next clk, then returns to RD_FETCH-idle (waiting for the next rx_valid).
REQ-021 In read mode, each later rx_valid (dummy byte) increments the address, then issues a new fetch; tx_data updates exactly 2 clk after that rx_valid.
REQ-022 Address increments modulo 2^ADDR_W; 127 wraps to 0 at the default width.
REQ-023 rx_valid during RD_WAIT or the bus_re cycle: the byte is dropped, overrun sets, and the fetch completes normally.
REQ-024 ss high in any state returns to IDLE the next clk, aborts pending strobes (no bus_we/bus_re issued afterwards), and holds tx_data.
REQ-025 overrun clears only on the IDLE -> CMD transition or reset.
REQ-026 rx_valid while in IDLE is ignored.
REQ-027 bus_we and bus_re are never high in the same cycle.
REQ-028 bus_addr holds its value between strobes.

Reset
REQ-029 On rst low: state=IDLE, tx_data=8'h00, bus_addr=0, bus_wdata=0, bus_we=0, bus_re=0, busy=0, overrun=0.
REQ-030 Reset release takes effect on the first rising clk edge with rst high; no output glitches during assertion.

Structure
REQ-031 Package spi_reg_pkg holds the state enum, CMD_RD_BIT (=7), and the STATUS_BYTE default.
REQ-032 Single module, no sub-module; address counter and FSM are inline.

Verification
REQ-033 ss low, command 8'h05, then data bytes 8'h11 and 8'h22 -> bus_we pulses at addr 5 with 8'h11 and at addr 6 with 8'h22; tx_data = 8'hA5 during the command.
REQ-034 ss low, command 8'h83, memory[3]=8'h3C, memory[4]=8'h4D, then two dummies -> tx_data = 8'h3C two clk after the command and 8'h4D two clk after the first dummy.
REQ-035 Write command 8'h7F, then 3 data bytes -> writes land at addresses 127, 0, 1 (wrap).
REQ-036 Read command, then rx_valid injected during RD_WAIT -> overrun=1, one bus_re only; next frame start clears overrun.
REQ-037 ss raised between rx_valid and the strobe cycle -> no bus_we issued, busy=0 next clk.
REQ-038 rst asserted mid-read -> all outputs at reset values asynchronously; a following frame operates normally.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared state encoding and constants for the SPI-to-register-bus bridge.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_WR       = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_WAIT  = 3'd4
  } state_t;

  localparam int         CMD_RD_BIT      = 7;
  localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI slave byte stream to register bus bridge: command byte sets mode and start
// address, following bytes are burst writes or dummy bytes that trigger reads.
//
// state       | meaning
// ST_IDLE     | deselected, waiting for ss low
// ST_CMD      | status byte on tx_data, waiting for command byte
// ST_WR       | write burst, each byte becomes a bus write
// ST_RD_FETCH | read burst; bus_re high = fetch issued, low = waiting for dummy byte
// ST_RD_WAIT  | bus_rdata valid, captured into tx_data
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t              state_q, state_nxt;
  logic [7:0]          tx_nxt, wdata_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                we_nxt, re_nxt, ovr_nxt;

  always_comb begin
    state_nxt = state_q;
    tx_nxt    = tx_data;
    // bus_addr doubles as the burst counter: it advances right after each write strobe
    addr_nxt  = bus_we ? bus_addr + ADDR_ONE : bus_addr;
    wdata_nxt = bus_wdata;
    we_nxt    = 1'b0;
    re_nxt    = 1'b0;
    ovr_nxt   = overrun;
    if (ss) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_nxt = ST_CMD;
          tx_nxt    = STATUS_BYTE;
          ovr_nxt   = 1'b0;
        end
        ST_CMD: begin
          if (rx_valid) begin
            addr_nxt = rx_data[ADDR_W-1:0];
            if (rx_data[CMD_RD_BIT]) begin
              state_nxt = ST_RD_FETCH;
              re_nxt    = 1'b1;
            end else begin
              state_nxt = ST_WR;
            end
          end
        end
        ST_WR: begin
          if (rx_valid) begin
            we_nxt    = 1'b1;
            wdata_nxt = rx_data;
          end
        end
        ST_RD_FETCH: begin
          if (bus_re) begin
            state_nxt = ST_RD_WAIT;
            if (rx_valid) ovr_nxt = 1'b1;
          end else if (rx_valid) begin
            addr_nxt = bus_addr + ADDR_ONE;
            re_nxt   = 1'b1;
          end
        end
        ST_RD_WAIT: begin
          state_nxt = ST_RD_FETCH;
          tx_nxt    = bus_rdata;
          if (rx_valid) ovr_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_data   <= 8'h00;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      tx_data   <= tx_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      bus_we    <= we_nxt;
      bus_re    <= re_nxt;
      overrun   <= ovr_nxt;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: driver pushes cycle-tagged expectations from a
// byte-level model, a negedge monitor pops and compares against the bus and tx_data.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst, ss, rx_valid;
  logic [7:0] rx_data, tx_data, bus_wdata;
  logic [7:0] bus_rdata = 8'h00;
  logic [6:0] bus_addr;
  logic       bus_we, bus_re, busy, overrun;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct { int cyc; logic [6:0] addr; logic [7:0] data; } ev_t;
  typedef struct { int cyc; logic busy; logic ovr; } st_t;

  ev_t exp_wr[$];
  ev_t exp_rd[$];
  ev_t exp_tx[$];
  st_t exp_st[$];

  logic [7:0] init_mem [128];
  logic [7:0] bus_mem  [128];
  logic [7:0] ref_mem  [128];
  logic       mem_loaded = 1'b0;
  logic [7:0] fq[$];

  // byte-level model state
  bit m_read;
  bit m_ovr;
  int m_addr;
  int m_last;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .ss(ss), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register file behind the bus: read data appears the cycle after bus_re
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) bus_mem[i] <= init_mem[i];
      mem_loaded <= 1'b1;
    end else if (bus_we) begin
      bus_mem[bus_addr] <= bus_wdata;
    end
    if (bus_re) bus_rdata <= bus_mem[bus_addr];
  end

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void flag(string name, int act);
    total++;
    bad++;
    $display("FAIL %s: got %0h want none (cyc %0d)", name, act, cyc);
  endfunction

  function automatic ev_t mk_ev(int c, int a, logic [7:0] d);
    mk_ev.cyc  = c;
    mk_ev.addr = 7'(a);
    mk_ev.data = d;
  endfunction

  function automatic st_t mk_st(int c, logic b, logic o);
    mk_st.cyc  = c;
    mk_st.busy = b;
    mk_st.ovr  = o;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    st_t s;
    if (bus_we && bus_re) flag("we_re_overlap", int'(bus_addr));
    if (bus_we) begin
      if (exp_wr.size() == 0) flag("unexpected_we_addr", int'(bus_addr));
      else begin
        e = exp_wr.pop_front();
        chk("we_cycle", cyc, e.cyc);
        chk("we_addr", int'(bus_addr), int'(e.addr));
        chk("we_data", int'(bus_wdata), int'(e.data));
      end
    end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
      e = exp_wr.pop_front();
      flag("missing_we_cycle", e.cyc);
    end
    if (bus_re) begin
      if (exp_rd.size() == 0) flag("unexpected_re_addr", int'(bus_addr));
      else begin
        e = exp_rd.pop_front();
        chk("re_cycle", cyc, e.cyc);
        chk("re_addr", int'(bus_addr), int'(e.addr));
      end
    end else if (exp_rd.size() != 0 && exp_rd[0].cyc <= cyc) begin
      e = exp_rd.pop_front();
      flag("missing_re_cycle", e.cyc);
    end
    while (exp_tx.size() != 0 && exp_tx[0].cyc <= cyc) begin
      e = exp_tx.pop_front();
      chk("tx_data", int'(tx_data), int'(e.data));
    end
    while (exp_st.size() != 0 && exp_st[0].cyc <= cyc) begin
      s = exp_st.pop_front();
      chk("busy", int'(busy), int'(s.busy));
      chk("overrun", int'(overrun), int'(s.ovr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_data"}, int'(tx_data), 0);
    chk({tag, "_bus_addr"}, int'(bus_addr), 0);
    chk({tag, "_bus_wdata"}, int'(bus_wdata), 0);
    chk({tag, "_bus_we"}, int'(bus_we), 0);
    chk({tag, "_bus_re"}, int'(bus_re), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic fetch(input int s);
    exp_rd.push_back(mk_ev(s, m_addr, 8'h00));
    exp_tx.push_back(mk_ev(s + 2, m_addr, ref_mem[m_addr]));
    m_last = s;
  endtask

  // s is the clock edge at which the DUT samples this byte
  task automatic send(input logic [7:0] b, input bit first);
    int s;
    s = cyc + 1;
    rx_valid = 1'b1;
    rx_data  = b;
    if (first) begin
      m_read = b[7];
      m_addr = int'(b[6:0]);
      if (m_read) fetch(s);
    end else if (m_read) begin
      if (s <= m_last + 2) m_ovr = 1'b1;
      else begin
        m_addr = (m_addr + 1) % 128;
        fetch(s);
      end
    end else begin
      exp_wr.push_back(mk_ev(s, m_addr, b));
      ref_mem[m_addr] = b;
      m_addr = (m_addr + 1) % 128;
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic begin_frame();
    ss    = 1'b0;
    m_ovr = 1'b0;
    exp_tx.push_back(mk_ev(cyc + 1, 0, 8'hA5));
    exp_st.push_back(mk_st(cyc + 1, 1'b1, 1'b0));
    tick();
    tick();
  endtask

  task automatic end_frame();
    repeat (4) tick();
    exp_st.push_back(mk_st(cyc + 1, 1'b1, m_ovr));
    tick();
    ss = 1'b1;
    exp_st.push_back(mk_st(cyc + 1, 1'b0, m_ovr));
    tick();
    tick();
  endtask

  task automatic run_frame(input int gap);
    int g;
    begin_frame();
    foreach (fq[i]) begin
      send(fq[i], i == 0);
      g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
      repeat (g) tick();
    end
    end_frame();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got cyc=%0d want finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst = 1'b1; ss = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 128; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    init_mem[3] = 8'h3C; ref_mem[3] = 8'h3C;
    init_mem[4] = 8'h4D; ref_mem[4] = 8'h4D;

    #3 rst = 1'b0;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // bytes while deselected are ignored
    rx_valid = 1'b1; rx_data = 8'h85;
    exp_st.push_back(mk_st(cyc + 1, 1'b0, 1'b0));
    tick();
    rx_valid = 1'b0;
    tick();

    fq = '{8'h83, 8'hAA, 8'h55};            run_frame(3);
    fq = '{8'h05, 8'h11, 8'h22};            run_frame(1);
    fq = '{8'h7F, 8'h01, 8'h02, 8'h03};     run_frame(0);
    fq = '{8'h90, 8'hFF};                   run_frame(1);
    fq = '{8'h8A, 8'h00, 8'h00};            run_frame(2);

    // deselect in the same cycle as a data byte: no write may follow
    begin_frame();
    send(8'h20, 1'b1);
    tick();
    rx_valid = 1'b1; rx_data = 8'h99; ss = 1'b1;
    exp_st.push_back(mk_st(cyc + 1, 1'b0, m_ovr));
    tick();
    rx_valid = 1'b0;
    tick(); tick();

    // asynchronous reset in the middle of a read with overrun pending
    begin_frame();
    send(8'hC0, 1'b1);
    send(8'h00, 1'b0);
    @(negedge clk);
    #1 chk("pre_rst_overrun", int'(overrun), int'(m_ovr));
    rst = 1'b0;
    #1 check_reset("mid");
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete(); exp_st.delete();
    m_ovr = 1'b0;
    ss = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    fq = '{8'h8A, 8'h00};                   run_frame(2);

    for (int f = 0; f < 14; f++) begin
      n = int'($urandom_range(1, 5));
      fq.delete();
      for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
      run_frame(-1);
    end

    repeat (5) tick();
    chk("leftover_we", exp_wr.size(), 0);
    chk("leftover_re", exp_rd.size(), 0);
    chk("leftover_tx", exp_tx.size(), 0);
    chk("leftover_st", exp_st.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
